// File: rtl/fifo_param_pkg.sv
// Shared constants for the parametrised FIFO: default geometry, thresholds
// and the read-mode encodings used by fifo_param and its storage array.
package fifo_param_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_AF_TH      = 12;
    localparam int DEF_AE_TH      = 2;

    // Integer values accepted on the SHOWAHEAD parameter
    localparam int FIFO_REGOUT    = 0;
    localparam int FIFO_SHOWAHEAD = 1;

    typedef enum logic {
        MODE_REGOUT    = 1'b0,
        MODE_SHOWAHEAD = 1'b1
    } fifo_mode_e;

    // Any non-zero SHOWAHEAD value selects show-ahead reads
    function automatic fifo_mode_e mode_from_param(input int showahead);
        if (showahead != 0) begin
            return MODE_SHOWAHEAD;
        end else begin
            return MODE_REGOUT;
        end
    endfunction

endpackage

// File: rtl/fifo_param_ram.sv
// Simple dual-port storage for fifo_param: one clocked write port and one
// asynchronous read port. Contents are deliberately not reset.
module fifo_param_ram
    import fifo_param_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  wren,
    input  logic [ADDR_WIDTH-1:0] wraddr,
    input  logic [DATA_WIDTH-1:0] wrdata,
    input  logic [ADDR_WIDTH-1:0] rdaddr,
    output logic [DATA_WIDTH-1:0] rddata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Write port: store the word on an accepted write
    always_ff @(posedge clock) begin
        if (wren) begin
            mem_r[wraddr] <= wrdata;
        end
    end

    assign rddata = mem_r[rdaddr];

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with fill level, almost-full/almost-empty
// thresholds, sticky overflow/underflow and selectable show-ahead or
// registered-output read mode. Pointers carry one extra wrap bit so the
// fill level is a plain modulo subtraction and full/empty never alias.
module fifo_param
    import fifo_param_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int AF_TH      = DEF_AF_TH,
    parameter int AE_TH      = DEF_AE_TH,
    parameter int SHOWAHEAD  = FIFO_SHOWAHEAD
) (
    input  logic                  clock,
    input  logic                  aclr,
    input  logic                  sclr,
    input  logic                  wrreq,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  rdreq,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   usedw,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_EXT    = (ADDR_WIDTH + 1)'(AF_TH);
    localparam logic [ADDR_WIDTH:0] AE_EXT    = (ADDR_WIDTH + 1)'(AE_TH);
    localparam logic [ADDR_WIDTH:0] ZERO_EXT  = {(ADDR_WIDTH + 1){1'b0}};
    localparam logic [ADDR_WIDTH:0] ONE_EXT   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam fifo_mode_e          MODE      = mode_from_param(SHOWAHEAD);

    // Reject threshold settings that would make a flag meaningless
    if ((AF_TH < 1) || (AF_TH > DEPTH) || (AE_TH < 0) || (AE_TH >= DEPTH)) begin : g_bad_thresholds
        $error("fifo_param: AF_TH must lie in 1..DEPTH and AE_TH in 0..DEPTH-1");
    end

    logic [ADDR_WIDTH:0]   wp_r;
    logic [ADDR_WIDTH:0]   rp_r;
    logic                  overflow_r;
    logic                  underflow_r;
    logic [DATA_WIDTH-1:0] q_r;

    logic [ADDR_WIDTH:0]   usedw_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  wr_accept_s;
    logic                  rd_accept_s;
    logic                  wr_reject_s;
    logic                  rd_reject_s;
    logic [DATA_WIDTH-1:0] ram_rdata_s;

    // Fill level and flags are derived purely from the registered pointers
    assign usedw_s = wp_r - rp_r;
    assign full_s  = (usedw_s == DEPTH_EXT);
    assign empty_s = (usedw_s == ZERO_EXT);

    // A synchronous clear suppresses any request made in the same cycle
    assign wr_accept_s = wrreq & ~full_s  & ~sclr;
    assign rd_accept_s = rdreq & ~empty_s & ~sclr;
    assign wr_reject_s = wrreq &  full_s  & ~sclr;
    assign rd_reject_s = rdreq &  empty_s & ~sclr;

    fifo_param_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clock  (clock),
        .wren   (wr_accept_s),
        .wraddr (wp_r[ADDR_WIDTH-1:0]),
        .wrdata (data),
        .rdaddr (rp_r[ADDR_WIDTH-1:0]),
        .rddata (ram_rdata_s)
    );

    // Write pointer: advances on each accepted write, wrap bit toggles at DEPTH
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            wp_r <= ZERO_EXT;
        end else if (sclr) begin
            wp_r <= ZERO_EXT;
        end else if (wr_accept_s) begin
            wp_r <= wp_r + ONE_EXT;
        end
    end

    // Read pointer: advances on each accepted read
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            rp_r <= ZERO_EXT;
        end else if (sclr) begin
            rp_r <= ZERO_EXT;
        end else if (rd_accept_s) begin
            rp_r <= rp_r + ONE_EXT;
        end
    end

    // Sticky error flags: set by a rejected request, cleared only by reset/clear
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (sclr) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            overflow_r  <= overflow_r  | wr_reject_s;
            underflow_r <= underflow_r | rd_reject_s;
        end
    end

    // Registered read data: loads the head word only on an accepted read
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            q_r <= {DATA_WIDTH{1'b0}};
        end else if (sclr) begin
            q_r <= {DATA_WIDTH{1'b0}};
        end else if (rd_accept_s) begin
            q_r <= ram_rdata_s;
        end
    end

    assign q            = (MODE == MODE_SHOWAHEAD) ? ram_rdata_s : q_r;
    assign usedw        = usedw_s;
    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = (usedw_s >= AF_EXT);
    assign almost_empty = (usedw_s <= AE_EXT);
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: a show-ahead and a registered-output instance share
// the same stimulus. A queue-based reference model tracks contents, sticky
// flags and registered q; a vector table and directed sequences cover the
// fill/drain, reset, wrap, concurrency and registered-read corner cases,
// followed by randomized traffic.
module tb_fifo_param;

    logic       clock = 1'b0;
    logic       aclr;
    logic       sclr;
    logic       wrreq;
    logic       rdreq;
    logic [7:0] data;

    logic [7:0] sa_q,  ro_q;
    logic       sa_full, sa_empty, sa_af, sa_ae, sa_ovf, sa_unf;
    logic       ro_full, ro_empty, ro_af, ro_ae, ro_ovf, ro_unf;
    logic [4:0] sa_usedw, ro_usedw;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [7:0] mq[$];
    logic       m_ovf;
    logic       m_unf;
    logic [7:0] m_qro;

    typedef struct {
        logic       w;
        logic       r;
        logic [7:0] d;
        int         eu;
        int         ef;
        int         ee;
        int         eaf;
        int         eae;
        int         eov;
        int         eun;
        int         eqro;
        int         eqsa;
    } vec_t;

    vec_t tbl[$];

    always #5 clock = ~clock;

    fifo_param dut_sa (
        .clock(clock), .aclr(aclr), .sclr(sclr), .wrreq(wrreq), .data(data), .rdreq(rdreq),
        .q(sa_q), .full(sa_full), .empty(sa_empty), .almost_full(sa_af), .almost_empty(sa_ae),
        .usedw(sa_usedw), .overflow(sa_ovf), .underflow(sa_unf)
    );

    fifo_param #(.SHOWAHEAD(0)) dut_ro (
        .clock(clock), .aclr(aclr), .sclr(sclr), .wrreq(wrreq), .data(data), .rdreq(rdreq),
        .q(ro_q), .full(ro_full), .empty(ro_empty), .almost_full(ro_af), .almost_empty(ro_ae),
        .usedw(ro_usedw), .overflow(ro_ovf), .underflow(ro_unf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_qro = 8'h00;
    endtask

    // Compare both instances against the reference model
    task automatic check_model();
        int n;
        n = mq.size();
        chk("m_usedw_sa", 32'(sa_usedw), n);
        chk("m_usedw_ro", 32'(ro_usedw), n);
        chk("m_full_sa",  32'(sa_full),  (n == 16) ? 1 : 0);
        chk("m_full_ro",  32'(ro_full),  (n == 16) ? 1 : 0);
        chk("m_empty_sa", 32'(sa_empty), (n == 0) ? 1 : 0);
        chk("m_empty_ro", 32'(ro_empty), (n == 0) ? 1 : 0);
        chk("m_af_sa",    32'(sa_af),    (n >= 12) ? 1 : 0);
        chk("m_af_ro",    32'(ro_af),    (n >= 12) ? 1 : 0);
        chk("m_ae_sa",    32'(sa_ae),    (n <= 2) ? 1 : 0);
        chk("m_ae_ro",    32'(ro_ae),    (n <= 2) ? 1 : 0);
        chk("m_ovf_sa",   32'(sa_ovf),   32'(m_ovf));
        chk("m_ovf_ro",   32'(ro_ovf),   32'(m_ovf));
        chk("m_unf_sa",   32'(sa_unf),   32'(m_unf));
        chk("m_unf_ro",   32'(ro_unf),   32'(m_unf));
        chk("m_q_ro",     32'(ro_q),     32'(m_qro));
        if (n != 0) begin
            chk("m_q_sa", 32'(sa_q), 32'(mq[0]));
        end
    endtask

    // One clock cycle: drive, update model at the edge, check 1 time unit later
    task automatic step(input logic w, input logic r, input logic s, input logic [7:0] d);
        bit was_full;
        bit was_empty;
        wrreq = w;
        rdreq = r;
        sclr  = s;
        data  = d;
        @(posedge clock);
        if (s) begin
            mdl_reset();
        end else begin
            was_full  = (mq.size() == 16);
            was_empty = (mq.size() == 0);
            if (r && !was_empty) m_qro = mq.pop_front();
            else if (r)          m_unf = 1'b1;
            if (w && !was_full)  mq.push_back(d);
            else if (w)          m_ovf = 1'b1;
        end
        #1;
        check_model();
    endtask

    initial begin
        vec_t v;
        int   wbias;
        int   rbias;

        aclr  = 1'b1;
        sclr  = 1'b0;
        wrreq = 1'b0;
        rdreq = 1'b0;
        data  = 8'h00;
        mdl_reset();

        // reset state, checked while aclr is still held
        #2;
        chk("rst_usedw", 32'(sa_usedw), 0);
        chk("rst_empty", 32'(sa_empty), 1);
        chk("rst_ae",    32'(sa_ae),    1);
        chk("rst_full",  32'(ro_full),  0);
        chk("rst_af",    32'(ro_af),    0);
        chk("rst_q_ro",  32'(ro_q),     0);
        #10;
        aclr = 1'b0;
        @(posedge clock);
        #1;

        // fill 0x00..0x10 then drain with one extra read
        for (int i = 0; i < 17; i++) begin
            v.w = 1'b1; v.r = 1'b0; v.d = 8'(i);
            v.eu   = (i < 16) ? i + 1 : 16;
            v.eov  = (i == 16) ? 1 : 0;
            v.eun  = 0;
            v.eqro = 0;
            v.eqsa = 0;
            tbl.push_back(v);
        end
        for (int j = 0; j < 17; j++) begin
            v.w = 1'b0; v.r = 1'b1; v.d = 8'h00;
            v.eu   = (j < 16) ? 15 - j : 0;
            v.eov  = 1;
            v.eun  = (j == 16) ? 1 : 0;
            v.eqro = (j < 16) ? j : 15;
            v.eqsa = j + 1;
            tbl.push_back(v);
        end
        for (int k = 0; k < tbl.size(); k++) begin
            tbl[k].ef  = (tbl[k].eu == 16) ? 1 : 0;
            tbl[k].ee  = (tbl[k].eu == 0)  ? 1 : 0;
            tbl[k].eaf = (tbl[k].eu >= 12) ? 1 : 0;
            tbl[k].eae = (tbl[k].eu <= 2)  ? 1 : 0;
        end
        foreach (tbl[k]) begin
            step(tbl[k].w, tbl[k].r, 1'b0, tbl[k].d);
            chk("tbl_usedw", 32'(sa_usedw), tbl[k].eu);
            chk("tbl_full",  32'(sa_full),  tbl[k].ef);
            chk("tbl_empty", 32'(ro_empty), tbl[k].ee);
            chk("tbl_af",    32'(sa_af),    tbl[k].eaf);
            chk("tbl_ae",    32'(ro_ae),    tbl[k].eae);
            chk("tbl_ovf",   32'(ro_ovf),   tbl[k].eov);
            chk("tbl_unf",   32'(sa_unf),   tbl[k].eun);
            chk("tbl_q_ro",  32'(ro_q),     tbl[k].eqro);
            if (tbl[k].eu != 0) chk("tbl_q_sa", 32'(sa_q), tbl[k].eqsa);
        end

        // asynchronous clear between clock edges
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'h30 + 8'(i));
        step(1'b0, 1'b1, 1'b0, 8'h00);
        aclr = 1'b1;
        #2;
        chk("aclr_usedw", 32'(sa_usedw), 0);
        chk("aclr_empty", 32'(ro_empty), 1);
        chk("aclr_ovf",   32'(sa_ovf),   0);
        chk("aclr_unf",   32'(ro_unf),   0);
        chk("aclr_q_ro",  32'(ro_q),     0);
        #2;
        aclr = 1'b0;
        mdl_reset();

        // pointer wrap: 10 in, 10 out, twice
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 8'(rep * 16 + i + 8'h40));
            for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
        end
        chk("wrap_usedw", 32'(sa_usedw), 0);

        // concurrent read+write at level 5, then at full
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'h80 + 8'(i));
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0, 8'h90 + 8'(i));
            chk("conc_usedw", 32'(sa_usedw), 5);
        end
        for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 1'b0, 8'hB0 + 8'(i));
        chk("conc_full", 32'(sa_full), 1);
        step(1'b1, 1'b1, 1'b0, 8'hEE);
        chk("conc_full_usedw", 32'(ro_usedw), 15);
        chk("conc_full_ovf",   32'(ro_ovf),   1);

        // registered-output read latency and hold
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'hA5);
        chk("ro_before_read", 32'(ro_q), 0);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        chk("ro_read_a5", 32'(ro_q), 32'h0000_00A5);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        chk("ro_hold_a5", 32'(ro_q), 32'h0000_00A5);
        chk("ro_unf",     32'(ro_unf), 1);
        step(1'b1, 1'b1, 1'b1, 8'h11);
        chk("ro_sclr_q",     32'(ro_q),     0);
        chk("ro_sclr_empty", 32'(ro_empty), 1);

        // randomized traffic with phases biased toward full and empty
        for (int ph = 0; ph < 8; ph++) begin
            wbias = (ph % 2 == 0) ? 75 : 30;
            rbias = (ph % 2 == 0) ? 30 : 75;
            for (int c = 0; c < 250; c++) begin
                step(($urandom_range(0, 99) < wbias) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 99) < rbias) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 127) == 0) ? 1'b1 : 1'b0,
                     8'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
